// File: rtl/gerador_sincronismo_vga_pkg.sv
// Shared timing constants for the VGA sync generator (640x480@60 Hz defaults).
// Also holds the counter width and the helper that sums porch/sync widths into a total.
package gerador_sincronismo_vga_pkg;

  localparam int CNT_W         = 10;
  localparam int CNT_MAX_TOTAL = 1 << CNT_W;

  localparam int DEF_H_VISIVEL = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIVEL = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  // 0 = active-low sync pulses, 1 = active-high
  localparam bit DEF_SYNC_POL  = 1'b0;

  function automatic int timing_total(input int visivel, input int front,
                                      input int sync, input int back);
    return visivel + front + sync + back;
  endfunction

  localparam int DEF_H_TOTAL = timing_total(DEF_H_VISIVEL, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int DEF_V_TOTAL = timing_total(DEF_V_VISIVEL, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

  typedef logic [CNT_W-1:0] contador_t;

endpackage

// File: rtl/gerador_sincronismo_vga_contador_modulo_n.sv
// Enabled modulo-N counter with a combinational terminal-count flag.
// Wraps through an explicit compare against N-1, never through natural overflow.
module contador_modulo_n #(
  parameter int N = 800,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         terminal
);

  localparam logic [W-1:0] ULTIMO = W'(N - 1);

  assign terminal = (count == ULTIMO);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= terminal ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/gerador_sincronismo_vga.sv
// VGA pixel/line timing generator: position counters plus sync, visible-area
// and end-of-line/frame decodes, advanced by a pixel-rate enable.
module gerador_sincronismo_vga
  import gerador_sincronismo_vga_pkg::*;
#(
  parameter int H_VISIVEL = DEF_H_VISIVEL,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIVEL = DEF_V_VISIVEL,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit SYNC_POL  = DEF_SYNC_POL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pixel_en,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             fim_h,
  output logic             fim_quadro,
  output logic             inicio_quadro
);

  localparam int H_TOTAL = timing_total(H_VISIVEL, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = timing_total(V_VISIVEL, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > CNT_MAX_TOTAL || V_TOTAL > CNT_MAX_TOTAL) begin : g_total_invalido
    $error("gerador_sincronismo_vga: H_TOTAL/V_TOTAL must not exceed %0d", CNT_MAX_TOTAL);
  end

  // Window bounds get one extra bit so a window ending exactly at 1024 still compares correctly.
  localparam int DW = CNT_W + 1;
  localparam logic [DW-1:0] H_VIS_FIM = DW'(H_VISIVEL);
  localparam logic [DW-1:0] HS_INI    = DW'(H_VISIVEL + H_FRONT);
  localparam logic [DW-1:0] HS_FIM    = DW'(H_VISIVEL + H_FRONT + H_SYNC);
  localparam logic [DW-1:0] V_VIS_FIM = DW'(V_VISIVEL);
  localparam logic [DW-1:0] VS_INI    = DW'(V_VISIVEL + V_FRONT);
  localparam logic [DW-1:0] VS_FIM    = DW'(V_VISIVEL + V_FRONT + V_SYNC);

  logic          fim_v;
  logic          avanca_v;
  logic [DW-1:0] h_ext;
  logic [DW-1:0] v_ext;
  logic          hsync_ativo;
  logic          vsync_ativo;

  contador_modulo_n #(.N(H_TOTAL), .W(CNT_W)) u_cont_h (
    .clk      (clk),
    .reset    (reset),
    .en       (pixel_en),
    .count    (hCount),
    .terminal (fim_h)
  );

  assign avanca_v = pixel_en & fim_h;

  contador_modulo_n #(.N(V_TOTAL), .W(CNT_W)) u_cont_v (
    .clk      (clk),
    .reset    (reset),
    .en       (avanca_v),
    .count    (vCount),
    .terminal (fim_v)
  );

  // NOTE: decodes are pure combinational functions of the registered counters,
  // so they change in the same cycle as hCount/vCount with no extra latency.
  assign h_ext       = {1'b0, hCount};
  assign v_ext       = {1'b0, vCount};
  assign hsync_ativo = (h_ext >= HS_INI) && (h_ext < HS_FIM);
  assign vsync_ativo = (v_ext >= VS_INI) && (v_ext < VS_FIM);
  assign hsync       = SYNC_POL ? hsync_ativo : ~hsync_ativo;
  assign vsync       = SYNC_POL ? vsync_ativo : ~vsync_ativo;
  assign video_on    = (h_ext < H_VIS_FIM) && (v_ext < V_VIS_FIM);
  assign fim_quadro  = fim_h & fim_v;

  // Sampled every clk, so a pulse set on the wrap edge clears on the very next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inicio_quadro <= 1'b0;
    end else begin
      inicio_quadro <= pixel_en & fim_quadro;
    end
  end

endmodule

// File: tb/tb_gerador_sincronismo_vga.sv
// Directed bench: default 640x480 instance for line timing, plus a narrow-line
// SYNC_POL=1/V_FRONT=3 instance for full-frame, enable-toggle and reset checks.
module tb_gerador_sincronismo_vga;
  import gerador_sincronismo_vga_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_a, en_a, hs_a, vs_a, von_a, fh_a, fq_a, ini_a;
  logic [CNT_W-1:0] h_a, v_a;
  logic             rst_b, en_b, hs_b, vs_b, von_b, fh_b, fq_b, ini_b;
  logic [CNT_W-1:0] h_b, v_b;

  int tests = 0;
  int fails = 0;

  gerador_sincronismo_vga u_def (
    .clk           (clk),
    .reset         (rst_a),
    .pixel_en      (en_a),
    .hCount        (h_a),
    .vCount        (v_a),
    .hsync         (hs_a),
    .vsync         (vs_a),
    .video_on      (von_a),
    .fim_h         (fh_a),
    .fim_quadro    (fq_a),
    .inicio_quadro (ini_a)
  );

  // Lines of 14 pixels: visible 0..7, hsync 10..12, fim_h at 13; V_TOTAL = 518.
  gerador_sincronismo_vga #(
    .H_VISIVEL (8),
    .H_FRONT   (2),
    .H_SYNC    (3),
    .H_BACK    (1),
    .V_FRONT   (3),
    .SYNC_POL  (1'b1)
  ) u_var (
    .clk           (clk),
    .reset         (rst_b),
    .pixel_en      (en_b),
    .hCount        (h_b),
    .vCount        (v_b),
    .hsync         (hs_b),
    .vsync         (vs_b),
    .video_on      (von_b),
    .fim_h         (fh_b),
    .fim_quadro    (fq_b),
    .inicio_quadro (ini_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  mh, mv, n_fq, n_ini, ini_cyc;
    bit  term;

    rst_a = 1'b1; en_a = 1'b1;
    rst_b = 1'b1; en_b = 1'b1;
    repeat (3) step();

    check("rst_h",      h_a,   0);
    check("rst_v",      v_a,   0);
    check("rst_hsync",  hs_a,  1);
    check("rst_vsync",  vs_a,  1);
    check("rst_video",  von_a, 1);
    check("rst_fim_h",  fh_a,  0);
    check("rst_fim_q",  fq_a,  0);
    check("rst_inicio", ini_a, 0);
    check("rst_b_hsync", hs_b, 0);
    check("rst_b_vsync", vs_b, 0);

    // Default instance: one full line, then the wrap into line 1.
    rst_a = 1'b0;
    for (int h = 1; h < 800; h++) begin
      step();
      check("a_h",      h_a,   h);
      check("a_v",      v_a,   0);
      check("a_fim_h",  fh_a,  (h == 799));
      check("a_hsync",  hs_a,  !(h >= 656 && h < 752));
      check("a_vsync",  vs_a,  1);
      check("a_video",  von_a, (h < 640));
      check("a_fim_q",  fq_a,  0);
      check("a_inicio", ini_a, 0);
    end
    step();
    check("a_wrap_h",     h_a,   0);
    check("a_wrap_v",     v_a,   1);
    check("a_wrap_fim_h", fh_a,  0);
    check("a_wrap_video", von_a, 1);

    en_a = 1'b0;
    repeat (4) step();
    check("a_hold_h", h_a, 0);
    check("a_hold_v", v_a, 1);
    en_a = 1'b1;
    step();
    check("a_resume_h", h_a, 1);

    // Variant instance: one full frame with pixel_en tied high.
    rst_b = 1'b0;
    mh = 0; mv = 0; n_fq = 0; n_ini = 0; ini_cyc = 0;
    for (int c = 1; c <= 7252; c++) begin
      term = (mh == 13 && mv == 517);
      if (mh == 13) begin
        mh = 0;
        mv = (mv == 517) ? 0 : mv + 1;
      end else begin
        mh++;
      end
      step();
      check("b_h",      h_b,   mh);
      check("b_v",      v_b,   mv);
      check("b_hsync",  hs_b,  (mh >= 10 && mh < 13));
      check("b_vsync",  vs_b,  (mv >= 483 && mv < 485));
      check("b_video",  von_b, (mh < 8 && mv < 480));
      check("b_fim_q",  fq_b,  (mh == 13 && mv == 517));
      check("b_inicio", ini_b, term);
      if (fq_b)  n_fq++;
      if (ini_b) begin n_ini++; ini_cyc = c; end
    end
    check("b_fim_q_count",  n_fq,    1);
    check("b_inicio_count", n_ini,   1);
    check("b_frame_len",    ini_cyc, 7252);

    // Second frame at half pixel rate: enabled on even clocks only.
    n_ini = 0; ini_cyc = 0;
    for (int c = 1; c <= 14505; c++) begin
      en_b = ((c % 2) == 0);
      term = en_b && (mh == 13 && mv == 517);
      if (en_b) begin
        if (mh == 13) begin
          mh = 0;
          mv = (mv == 517) ? 0 : mv + 1;
        end else begin
          mh++;
        end
      end
      step();
      check("b2_h",      h_b,   mh);
      check("b2_v",      v_b,   mv);
      check("b2_inicio", ini_b, term);
      if (ini_b) begin n_ini++; ini_cyc = c; end
    end
    check("b2_inicio_count", n_ini,   1);
    check("b2_frame_len",    ini_cyc, 14504);

    // Run to (11, 300), then reset between clock edges.
    en_b = 1'b1;
    for (int c = 0; c < 10000 && !(mh == 11 && mv == 300); c++) begin
      if (mh == 13) begin
        mh = 0;
        mv = (mv == 517) ? 0 : mv + 1;
      end else begin
        mh++;
      end
      step();
    end
    check("mid_h",     h_b,  11);
    check("mid_v",     v_b,  300);
    check("mid_hsync", hs_b, 1);
    #2;
    rst_b = 1'b1;
    #1;
    check("arst_h",      h_b,   0);
    check("arst_v",      v_b,   0);
    check("arst_hsync",  hs_b,  0);
    check("arst_vsync",  vs_b,  0);
    check("arst_video",  von_b, 1);
    check("arst_inicio", ini_b, 0);
    step();
    check("arst_hold_inicio", ini_b, 0);
    rst_b = 1'b0;
    step();
    check("post_rst_h",      h_b,   1);
    check("post_rst_inicio", ini_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
